// File: rtl/kmeans_pkg.sv
// Shared K-means constants, centroid-update FSM encoding and the channel saturation helper.
package kmeans_pkg;

    localparam int SIZE_OF_ACC    = 24;
    localparam int SIZE_OF_COUNT  = 12;
    localparam int NUM_OF_ENGINES = 2;
    localparam int SIZE_OF_PIXEL  = 8;
    localparam int NUM_CHANNELS   = 3;

    // Reduced sum/count widths grow by one bit per upstream engine.
    localparam int SUM_W   = SIZE_OF_ACC + NUM_OF_ENGINES;
    localparam int COUNT_W = SIZE_OF_COUNT + NUM_OF_ENGINES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Clamp a quotient to the largest value a pix_w-bit channel can hold.
    function automatic logic [63:0] saturate(input logic [63:0] q, input int unsigned pix_w);
        logic [63:0] max_val;
        max_val = (64'd1 << pix_w) - 64'd1;
        return (q > max_val) ? max_val : q;
    endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One channel of a bit-serial restoring divider: dividend shifts out MSB-first while
// quotient bits shift in at the LSB of the same register.
module seq_divider_step
    import kmeans_pkg::*;
#(
    parameter int QW = SUM_W,
    parameter int VW = COUNT_W
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic          step,
    input  logic [QW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [QW-1:0] quotient
);

    logic [QW-1:0] work_reg;
    logic [VW-1:0] rem_reg;
    logic [VW:0]   trial;
    logic          ge;
    logic [VW-1:0] rem_next;

    // The restored remainder is always below the divisor, so VW bits suffice to store it.
    always_comb begin
        trial    = {rem_reg, work_reg[QW-1]};
        ge       = (trial >= {1'b0, divisor});
        rem_next = ge ? (trial[VW-1:0] - divisor) : trial[VW-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            work_reg <= '0;
            rem_reg  <= '0;
        end else if (load) begin
            work_reg <= dividend;
            rem_reg  <= '0;
        end else if (step) begin
            rem_reg  <= rem_next;
            work_reg <= {work_reg[QW-2:0], ge};
        end
    end

    assign quotient = work_reg;

endmodule

// File: rtl/centroid_update_unit.sv
// Divides the reduced R/G/B sums by the member count to form the next cluster centroid.
// Define CENTROID_ROUND_NEAREST_EN for round-half-up division (one extra cycle of latency).
module centroid_update_unit
    import kmeans_pkg::*;
#(
    parameter int SizeOfAcc    = 24,
    parameter int SizeOfCount  = 12,
    parameter int NumOfEngines = 2,
    parameter int SizeOfPixel  = 8
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  start,
    input  logic [SizeOfAcc+NumOfEngines-1:0]     red_sum,
    input  logic [SizeOfAcc+NumOfEngines-1:0]     green_sum,
    input  logic [SizeOfAcc+NumOfEngines-1:0]     blue_sum,
    input  logic [SizeOfCount+NumOfEngines-1:0]   co_sum,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  empty,
    output logic [3*SizeOfPixel-1:0]              centroid
);

    localparam int DW = SizeOfAcc + NumOfEngines;
    localparam int VW = SizeOfCount + NumOfEngines;
`ifdef CENTROID_ROUND_NEAREST_EN
    localparam int QW = DW + 1;
`else
    localparam int QW = DW;
`endif
    localparam int IW = $clog2(QW + 1);

    state_t                   state_reg;
    logic [IW-1:0]            iter_reg;
    logic [VW-1:0]            divisor_reg;
    logic                     zero_reg;
    logic                     load;
    logic                     step;
    logic [DW-1:0]            sums [NUM_CHANNELS];
    logic [QW-1:0]            dividend [NUM_CHANNELS];
    logic [QW-1:0]            quotient [NUM_CHANNELS];
    logic [3*SizeOfPixel-1:0] centroid_next;

    assign sums[0] = red_sum;
    assign sums[1] = green_sum;
    assign sums[2] = blue_sum;

    assign load = (state_reg == IDLE) && start && (co_sum != '0);
    assign step = (state_reg == DIV);

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
`ifdef CENTROID_ROUND_NEAREST_EN
        // Adding half the divisor before truncating rounds half-up; the extra bit keeps the carry.
        assign dividend[gi] = {1'b0, sums[gi]} + QW'(co_sum >> 1);
`else
        assign dividend[gi] = sums[gi];
`endif

        seq_divider_step #(
            .QW (QW),
            .VW (VW)
        ) u_div (
            .clk      (clk),
            .reset_n  (reset_n),
            .load     (load),
            .step     (step),
            .dividend (dividend[gi]),
            .divisor  (divisor_reg),
            .quotient (quotient[gi])
        );

        // Channel 0 (red) lands in the most significant byte.
        assign centroid_next[(NUM_CHANNELS-1-gi)*SizeOfPixel +: SizeOfPixel] =
            SizeOfPixel'(saturate(64'(quotient[gi]), SizeOfPixel));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            iter_reg    <= '0;
            divisor_reg <= '0;
            zero_reg    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            empty       <= 1'b0;
            centroid    <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        empty <= 1'b0;
                        if (co_sum != '0) begin
                            divisor_reg <= co_sum;
                            iter_reg    <= '0;
                            zero_reg    <= 1'b0;
                            busy        <= 1'b1;
                            state_reg   <= DIV;
                        end else begin
                            zero_reg  <= 1'b1;
                            state_reg <= FIN;
                        end
                    end
                end
                DIV: begin
                    iter_reg <= iter_reg + 1'b1;
                    if (iter_reg == IW'(QW - 1)) begin
                        state_reg <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    empty <= zero_reg;
                    if (!zero_reg) begin
                        centroid <= centroid_next;
                    end
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_centroid_update_unit.sv
// Directed bench for centroid_update_unit; expectations follow CENTROID_ROUND_NEAREST_EN if defined.
module tb_centroid_update_unit;

`ifdef CENTROID_ROUND_NEAREST_EN
    localparam int LAT   = 28;
    localparam bit ROUND = 1'b1;
`else
    localparam int LAT   = 27;
    localparam bit ROUND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [25:0] red_sum, green_sum, blue_sum;
    logic [13:0] co_sum;
    logic        busy, done, empty;
    logic [23:0] centroid;

    int checks = 0;
    int errors = 0;
    int lat;
    int ndone;
    logic busy_seen;

    always #5 clk = ~clk;

    centroid_update_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .red_sum   (red_sum),
        .green_sum (green_sum),
        .blue_sum  (blue_sum),
        .co_sum    (co_sum),
        .busy      (busy),
        .done      (done),
        .empty     (empty),
        .centroid  (centroid)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge, then wait (bounded) for done; lat = edges after the start edge.
    task automatic run_op(input logic [25:0] r, input logic [25:0] g, input logic [25:0] b,
                          input logic [13:0] c, output int lat_o, output logic busy_o);
        @(negedge clk);
        red_sum = r; green_sum = g; blue_sum = b; co_sum = c; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        busy_o = busy;
        lat_o = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat_o = i;
                break;
            end
        end
        if (lat_o < 0) check("done_timeout", {63'd0, done}, 64'd1);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) n++;
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0;
        red_sum = '0; green_sum = '0; blue_sum = '0; co_sum = '0;
        #2;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_empty", {63'd0, empty}, 64'd0);
        check("reset_centroid", {40'd0, centroid}, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Basic: 1000/10, 2550/10, 0/10
        run_op(26'd1000, 26'd2550, 26'd0, 14'd10, lat, busy_seen);
        $display("op basic: lat=%0d centroid=%06h empty=%0b", lat, centroid, empty);
        check("basic_busy_during", {63'd0, busy_seen}, 64'd1);
        check("basic_latency", 64'(lat), 64'(LAT));
        check("basic_centroid", {40'd0, centroid}, 64'h64FF00);
        check("basic_empty", {63'd0, empty}, 64'd0);
        check("basic_busy_after", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        check("basic_done_pulse", {63'd0, done}, 64'd0);

        // Load 0x102030, then an empty cluster must leave it in place
        run_op(26'd64, 26'd128, 26'd192, 14'd4, lat, busy_seen);
        $display("op load: lat=%0d centroid=%06h", lat, centroid);
        check("load_centroid", {40'd0, centroid}, 64'h102030);
        run_op(26'd999, 26'd999, 26'd999, 14'd0, lat, busy_seen);
        $display("op empty: lat=%0d centroid=%06h empty=%0b", lat, centroid, empty);
        check("empty_latency_le2", {63'd0, (lat >= 1 && lat <= 2)}, 64'd1);
        check("empty_busy_during", {63'd0, busy_seen}, 64'd0);
        check("empty_flag", {63'd0, empty}, 64'd1);
        check("empty_centroid_held", {40'd0, centroid}, 64'h102030);
        repeat (3) @(posedge clk); #1;
        check("empty_sticky", {63'd0, empty}, 64'd1);

        // Saturation: red 5000 clips, others pass
        run_op(26'd5000, 26'd7, 26'd255, 14'd1, lat, busy_seen);
        $display("op sat: lat=%0d centroid=%06h empty=%0b", lat, centroid, empty);
        check("sat_empty_cleared", {63'd0, empty}, 64'd0);
        check("sat_centroid", {40'd0, centroid}, 64'hFF07FF);

        // Boundary around 255/256
        run_op(26'd767, 26'd768, 26'd2, 14'd3, lat, busy_seen);
        $display("op boundary: lat=%0d centroid=%06h", lat, centroid);
        check("boundary_centroid", {40'd0, centroid}, ROUND ? 64'hFFFF01 : 64'hFFFF00);

        // Rounding: 25/10, 14/10, 15/10
        run_op(26'd25, 26'd14, 26'd15, 14'd10, lat, busy_seen);
        $display("op round: lat=%0d centroid=%06h", lat, centroid);
        check("round_centroid", {40'd0, centroid}, ROUND ? 64'h030102 : 64'h020101);

        // Start while busy is ignored
        @(negedge clk);
        red_sum = 26'd300; green_sum = 26'd600; blue_sum = 26'd900; co_sum = 14'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        red_sum = 26'd30; green_sum = 26'd30; blue_sum = 26'd30; co_sum = 14'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        count_dones(50, ndone);
        $display("op busy_start: dones=%0d centroid=%06h", ndone, centroid);
        check("busy_start_dones", 64'(ndone), 64'd1);
        check("busy_start_centroid", {40'd0, centroid}, 64'h64C8FF);

        // Reset mid-division
        @(negedge clk);
        red_sum = 26'd1000; green_sum = 26'd1000; blue_sum = 26'd1000; co_sum = 14'd10; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (12) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        $display("op reset_mid: busy=%0b done=%0b centroid=%06h", busy, done, centroid);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_centroid", {40'd0, centroid}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        count_dones(40, ndone);
        check("rst_no_done", 64'(ndone), 64'd0);
        run_op(26'd500, 26'd250, 26'd125, 14'd5, lat, busy_seen);
        $display("op after_reset: lat=%0d centroid=%06h", lat, centroid);
        check("after_rst_latency", 64'(lat), 64'(LAT));
        check("after_rst_centroid", {40'd0, centroid}, 64'h643219);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
